parity_frame_deserializer: RTL

- Serial-to-parallel front end for the parity checker stage.
- Collects a framed serial bit stream: DATA_WIDTH data bits followed by one parity bit.
- Presents the assembled word and its received parity bit as registered parallel outputs, with a one-cycle frame_valid strobe.
- Downstream stage consumes data_out/parity_out directly; this block performs no parity computation itself.

---
 rtl/parity_frame_deserializer.sv | 96 +++++++++
 1 files changed

// File: rtl/parity_frame_deserializer.sv
// Serial-to-parallel front end: gathers DATA_WIDTH data bits plus one parity bit per
// frame and presents them as registered parallel outputs with a one-cycle strobe.
module parity_frame_deserializer #(
  parameter int DATA_WIDTH = 32,
  parameter bit MSB_FIRST  = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  sof,
  input  logic                  serial_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  parity_out,
  output logic                  frame_valid,
  output logic                  frame_abort
);

  localparam int CW = $clog2(DATA_WIDTH + 1);
  localparam logic [CW-1:0] LAST_IDX = CW'(DATA_WIDTH - 1);
  // Position of serial data bit 0 inside the word; later bits walk away from it.
  localparam logic [DATA_WIDTH-1:0] FIRST_MASK =
    MSB_FIRST ? (DATA_WIDTH'(1) << (DATA_WIDTH - 1)) : DATA_WIDTH'(1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY} state_t;

  localparam state_t START_STATE = (DATA_WIDTH == 1) ? PARITY : DATA;

  state_t                  state, state_next;
  logic [CW-1:0]           cnt, cnt_next;
  logic [DATA_WIDTH-1:0]   shift, shift_next;
  logic [DATA_WIDTH-1:0]   data_next;
  logic                    parity_next;
  logic                    valid_next;
  logic                    abort_next;
  logic [DATA_WIDTH-1:0]   bit_mask;

  assign bit_mask = MSB_FIRST ? (FIRST_MASK >> cnt) : (FIRST_MASK << cnt);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      shift       <= '0;
      data_out    <= '0;
      parity_out  <= 1'b0;
      frame_valid <= 1'b0;
      frame_abort <= 1'b0;
    end else begin
      state       <= state_next;
      cnt         <= cnt_next;
      shift       <= shift_next;
      data_out    <= data_next;
      parity_out  <= parity_next;
      frame_valid <= valid_next;
      frame_abort <= abort_next;
    end
  end

  always_comb begin
    state_next  = state;
    cnt_next    = cnt;
    shift_next  = shift;
    data_next   = data_out;
    parity_next = parity_out;
    valid_next  = 1'b0;
    abort_next  = 1'b0;

    if (en) begin
      if (sof) begin
        // A sof always restarts; only a frame already in flight counts as an abort.
        abort_next = (state != IDLE);
        shift_next = serial_in ? FIRST_MASK : '0;
        cnt_next   = CW'(1);
        state_next = START_STATE;
      end else begin
        unique case (state)
          IDLE: ;
          DATA: begin
            shift_next = serial_in ? (shift | bit_mask) : (shift & ~bit_mask);
            cnt_next   = cnt + CW'(1);
            if (cnt == LAST_IDX) state_next = PARITY;
          end
          PARITY: begin
            data_next   = shift;
            parity_next = serial_in;
            valid_next  = 1'b1;
            cnt_next    = '0;
            state_next  = IDLE;
          end
          default: state_next = IDLE;
        endcase
      end
    end
  end

endmodule
